// File: rtl/pzbcm_stream_merger.sv
// rtl/pzbcm_stream_merger.sv - round-robin packet-locking merge of N valid/ready streams
// onto one registered output; o_select encodes the source of the buffered beat.
module pzbcm_stream_merger #(
  parameter int  WIDTH   = 8,
  parameter type TYPE    = logic [WIDTH-1:0],
  parameter int  ENTRIES = 2,
  parameter bit  ONE_HOT = 1,
  localparam int SELECT_WIDTH = ONE_HOT ? ENTRIES : ((ENTRIES > 1) ? $clog2(ENTRIES) : 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [ENTRIES-1:0]      i_valid,
  output logic [ENTRIES-1:0]      o_ready,
  input  TYPE                     i_data [ENTRIES],
  input  logic [ENTRIES-1:0]      i_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output TYPE                     o_data,
  output logic                    o_last,
  output logic [SELECT_WIDTH-1:0] o_select
);

  localparam int INDEX_WIDTH = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                   state;
  logic [INDEX_WIDTH-1:0]   lock_index;
  logic [INDEX_WIDTH-1:0]   rr_pointer;
  logic [ENTRIES-1:0]       grant;
  logic [INDEX_WIDTH-1:0]   grant_index;
  logic [SELECT_WIDTH-1:0]  select_next;
  logic                     found;
  logic                     load;
  logic                     accept;

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    found       = 1'b0;
    if (state == LOCKED) begin
      grant[lock_index] = 1'b1;
      grant_index       = lock_index;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!found && (i >= int'(rr_pointer)) && i_valid[i]) begin
          found       = 1'b1;
          grant_index = INDEX_WIDTH'(i);
        end
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (!found && i_valid[i]) begin
          found       = 1'b1;
          grant_index = INDEX_WIDTH'(i);
        end
      end
      if (found) begin
        grant[grant_index] = 1'b1;
      end
    end
  end

  assign load    = !o_valid || i_ready;
  assign o_ready = load ? grant : '0;
  assign accept  = |(i_valid & o_ready);

  if (ONE_HOT) begin : g_one_hot
    always_comb begin
      select_next              = '0;
      select_next[grant_index] = 1'b1;
    end
  end else begin : g_binary
    assign select_next = SELECT_WIDTH'(grant_index);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      lock_index <= '0;
      rr_pointer <= '0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_last     <= 1'b0;
      o_select   <= '0;
    end else begin
      if (load) begin
        o_valid <= accept;
        if (accept) begin
          o_data   <= i_data[grant_index];
          o_last   <= i_last[grant_index];
          o_select <= select_next;
        end
      end
      if (accept) begin
        if (i_last[grant_index]) begin
          state <= IDLE;
          if (grant_index == INDEX_WIDTH'(ENTRIES - 1)) begin
            rr_pointer <= '0;
          end else begin
            rr_pointer <= grant_index + 1'b1;
          end
        end else begin
          state      <= LOCKED;
          lock_index <= grant_index;
        end
      end
    end
  end

endmodule

// File: tb/tb_pzbcm_stream_merger.sv
// tb/tb_pzbcm_stream_merger.sv - directed scoreboard bench for pzbcm_stream_merger
// (4 sources, one-hot and binary select instances driven in parallel).
module tb_pzbcm_stream_merger;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         src;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] src_valid;
  logic [3:0] src_last;
  logic [7:0] src_data [4];
  logic       out_ready;
  logic [3:0] ready_a, ready_b;
  logic       valid_a, valid_b;
  logic [7:0] data_a, data_b;
  logic       last_a, last_b;
  logic [3:0] select_a;
  logic [1:0] select_b;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  pzbcm_stream_merger #(.WIDTH(8), .ENTRIES(4), .ONE_HOT(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(src_valid), .o_ready(ready_a),
    .i_data(src_data), .i_last(src_last), .o_valid(valid_a), .i_ready(out_ready),
    .o_data(data_a), .o_last(last_a), .o_select(select_a)
  );

  pzbcm_stream_merger #(.WIDTH(8), .ENTRIES(4), .ONE_HOT(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(src_valid), .o_ready(ready_b),
    .i_data(src_data), .i_last(src_last), .o_valid(valid_b), .i_ready(out_ready),
    .o_data(data_b), .o_last(last_b), .o_select(select_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of source inputs, check the expected handshake, record the accepted beat.
  task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic rdy, input logic [3:0] exp_rdy);
    src_valid = v;
    src_last  = l;
    out_ready = rdy;
    #1;
    check("o_ready_onehot", ready_a, exp_rdy);
    check("o_ready_binary", ready_b, exp_rdy);
    for (int g = 0; g < 4; g++) begin
      if (exp_rdy[g] && v[g]) sb.push_back('{src_data[g], l[g], g});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && valid_a && out_ready) begin
        check("sb_depth", sb.size() > 0, 1);
        check("o_valid_binary", valid_b, 1);
        if (sb.size() > 0) begin
          beat_t e;
          e = sb.pop_front();
          check("o_data", data_a, e.data);
          check("o_last", last_a, e.last);
          check("o_select_onehot", select_a, 32'(1 << e.src));
          check("o_select_binary", select_b, e.src);
          check("o_data_binary", data_b, e.data);
          check("o_last_binary", last_b, e.last);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    src_valid = '0;
    src_last  = '0;
    for (int i = 0; i < 4; i++) src_data[i] = 8'(8'h20 + i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_o_valid", valid_a, 0);
    check("reset_o_data", data_a, 0);
    check("reset_o_last", last_a, 0);
    check("reset_o_select", select_a, 0);
    check("reset_o_ready", ready_a, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single beat from source 2
    src_data[2] = 8'h5A;
    cycle(4'b0100, 4'b0100, 1'b1, 4'b0100);
    check("single_o_valid", valid_a, 1);
    check("single_o_data", data_a, 8'h5A);
    check("single_o_last", last_a, 1);
    check("single_o_select", select_a, 4'b0100);
    cycle(4'b0000, 4'b0000, 1'b1, 4'b0000);

    // round robin, pointer now at 3
    for (int i = 0; i < 4; i++) src_data[i] = 8'(8'h20 + i);
    for (int k = 0; k < 8; k++) cycle(4'b1111, 4'b1111, 1'b1, 4'(1 << ((3 + k) % 4)));

    // packet lock: move pointer to 1, then 3-beat packet from source 1 against source 0
    cycle(4'b0001, 4'b0001, 1'b1, 4'b0001);
    src_data[0] = 8'h30;
    src_data[1] = 8'h10;
    cycle(4'b0011, 4'b0001, 1'b1, 4'b0010);
    src_data[1] = 8'h11;
    cycle(4'b0011, 4'b0001, 1'b1, 4'b0010);
    src_data[1] = 8'h12;
    cycle(4'b0011, 4'b0011, 1'b1, 4'b0010);
    cycle(4'b0001, 4'b0001, 1'b1, 4'b0001);

    // backpressure with a buffered beat, then pointer wrap from source 3 to 0
    src_data[2] = 8'h42;
    src_data[3] = 8'h43;
    src_data[0] = 8'h44;
    cycle(4'b0100, 4'b0100, 1'b1, 4'b0100);
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1000, 4'b1000, 1'b0, 4'b0000);
      check("stall_o_valid", valid_a, 1);
      check("stall_o_data", data_a, 8'h42);
      check("stall_o_select", select_a, 4'b0100);
    end
    cycle(4'b1000, 4'b1000, 1'b1, 4'b1000);
    cycle(4'b1001, 4'b1001, 1'b1, 4'b0001);
    cycle(4'b0000, 4'b0000, 1'b1, 4'b0000);

    // reset after the first beat of a 3-beat packet from source 2
    src_data[2] = 8'h70;
    cycle(4'b0100, 4'b0000, 1'b1, 4'b0100);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_reset_o_valid", valid_a, 0);
    check("async_reset_o_data", data_a, 0);
    check("async_reset_o_select", select_a, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    src_data[0] = 8'h80;
    src_data[2] = 8'h71;
    cycle(4'b0101, 4'b0001, 1'b1, 4'b0001);
    cycle(4'b0000, 4'b0000, 1'b1, 4'b0000);
    cycle(4'b0000, 4'b0000, 1'b1, 4'b0000);
    check("sb_drained", sb.size(), 0);
    check("final_o_valid", valid_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pzbcm_stream_merger.md
# pzbcm_stream_merger

Merges `ENTRIES` valid/ready source streams onto one registered output stream with round-robin arbitration and packet locking. It is the collecting counterpart of `pzbcm_demux`. `o_select` reports the winning source in the same encoding as the demux select input, so a response path can be routed back through `pzbcm_demux` unchanged. It sits in front of shared buses, shared pipelines and request queues.

## Interface
- `WIDTH`, 8: payload width.
- `TYPE`, `logic[WIDTH-1:0]`: payload type.
- `ENTRIES`, 2: number of sources, ≥1.
- `ONE_HOT`, 1: `o_select` encoding. One-hot when 1, binary when 0.
- `SELECT_WIDTH` (localparam): `ONE_HOT ? ENTRIES : $clog2(ENTRIES)`, minimum 1.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_valid`  in  `[ENTRIES]`  source valid.
- `o_ready`  out  `[ENTRIES]`  source ready.
- `i_data`  in  `TYPE [ENTRIES]`  source payload.
- `i_last`  in  `[ENTRIES]`  last beat of packet.
- `o_valid`  out  1  output valid.
- `i_ready`  in  1  output ready.
- `o_data`  out  `TYPE`  output payload.
- `o_last`  out  1  output last.
- `o_select`  out  `SELECT_WIDTH`  source index of the beat in `o_data`.

## Operation
- **Output register.** Holds `o_valid`, `o_data`, `o_last`, `o_select`.
  - `load = !o_valid || i_ready`.
  - Source i is accepted when `i_valid[i] && o_ready[i]`.
- **Ready.** `o_ready[i] = load && grant[i]`. At most one `o_ready` bit is high in any cycle.
- **State machine.** States are IDLE and LOCKED. Registers are `lock_index` and `rr_pointer`.
- **IDLE.**
  - `grant` is combinational: the first asserted `i_valid[k]` searching k = `rr_pointer`, `rr_pointer`+1, … wrapping modulo ENTRIES.
  - No valid source means no grant.
- **LOCKED.**
  - `grant` is one-hot at `lock_index`, regardless of other sources.
  - Other sources see `o_ready` low.
- **On an accepted beat from source g:**
  - `i_last[g]` = 0: next state LOCKED, `lock_index` = g.
  - `i_last[g]` = 1: next state IDLE, `rr_pointer` = (g+1) mod ENTRIES.
- An IDLE beat with `i_last` = 1 is a single-beat packet. It does not lock.
- `rr_pointer` changes only on an accepted last beat.
- **Load behaviour.**
  - When `load` is high and a beat is accepted, the register takes `i_data[g]`, `i_last[g]` and the encoded g, and `o_valid` = 1.
  - When `load` is high and nothing is accepted, `o_valid` = 0 and data/last/select hold their old values.
- **Source rule.** A source holds `i_valid`, `i_data` and `i_last` stable until accepted. The block does not check this.
- **ENTRIES = 1.**
  - `rr_pointer` is constant 0.
  - `o_select` is 1 when `ONE_HOT` = 1, and 0 otherwise.
- **Reset values.** `o_valid` 0, `o_data` 0, `o_last` 0, `o_select` 0, state IDLE, `rr_pointer` 0.
- **Reset mid-packet.** Lock and pointer are dropped, and any buffered beat is lost.

## Timing
- Latency is 1 cycle: a beat accepted at edge n is on `o_*` after edge n.
- Full throughput: one beat per cycle while `i_ready` is held high.
- `o_ready` is combinational from `i_valid` (IDLE only), `i_ready`, state and `o_valid`. There is no path from `i_data` to any output.
- Output stall:
  - `o_valid` = 1 and `i_ready` = 0 give `load` = 0.
  - All `o_ready` bits are 0, and `o_*` hold stable.
- Simultaneous events:
  - The output beat leaves and a new beat enters in the same cycle.
  - A last beat accepted in cycle n makes the new arbitration effective in cycle n+1 from the updated pointer.
- Arbitration decision:
  - Made in the same cycle the source is presented while IDLE and `load` is high.
  - Not registered ahead of time.

## Test plan
- **Single source.** ENTRIES=4, ONE_HOT=1, `i_ready`=1, source 2 sends 0x5A with last.
  - `o_ready[2]`=1 that cycle.
  - Next cycle: `o_valid`=1, `o_data`=0x5A, `o_last`=1, `o_select`=4'b0100.
- **Round-robin.** All four sources continuously valid with single-beat packets, `i_ready`=1.
  - `o_select` sequence 0,1,2,3,0,… (one-hot), one beat per cycle.
  - With ONE_HOT=0 the sequence is binary 0,1,2,3.
- **Packet lock.** Source 1 sends 3 beats (0x10, 0x11, 0x12 last) while source 0 is valid throughout.
  - `o_ready[0]` stays 0 until after 0x12 is accepted.
  - Output order: 0x10, 0x11, 0x12, then source 0's beat.
- **Backpressure.** `i_ready`=0 for 5 cycles with `o_valid`=1.
  - `o_data` and `o_select` stay constant.
  - All `o_ready` bits are 0.
  - After `i_ready` rises, beats resume with no loss or duplication, checked against a scoreboard.
- **Pointer wrap.** Source 3 completes a packet.
  - `rr_pointer` becomes 0.
  - With sources 0 and 3 both valid next, source 0 is granted.
- **Reset mid-packet.** Assert `i_rst_n`=0 asynchronously after the first beat of a 3-beat packet from source 2.
  - `o_valid` is 0 immediately.
  - After release, source 0 valid is granted first (state IDLE, pointer 0).
